// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one cache-line memory port between ICache fills and DCache fills/write-backs.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise DCache wins ties.
`timescale 1ns/1ps
module mem_bus_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req_valid,
    output logic                  i_req_ready,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    output logic                  i_res_valid,
    input  logic                  i_res_ready,
    output logic [LINE_WIDTH-1:0] i_res_Rdata,
    input  logic                  d_req_valid,
    output logic                  d_req_ready,
    input  logic [ADDR_WIDTH-1:0] d_req_addr,
    input  logic                  d_write_en,
    input  logic [LINE_WIDTH-1:0] d_req_Wdata,
    output logic                  d_res_valid,
    input  logic                  d_res_ready,
    output logic [LINE_WIDTH-1:0] d_res_Rdata,
    output logic [1:0]            d_axi_Wdone,
    output logic                  m_req_valid,
    input  logic                  m_req_ready,
    output logic [ADDR_WIDTH-1:0] m_req_addr,
    output logic                  m_write_en,
    output logic [LINE_WIDTH-1:0] m_req_Wdata,
    input  logic                  m_res_valid,
    output logic                  m_res_ready,
    input  logic [LINE_WIDTH-1:0] m_res_Rdata,
    input  logic [1:0]            m_axi_Wdone
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT_RD, WAIT_WR} state_t;
    state_t state;
    logic   grant;
    logic   pick;
    logic   in_req, in_rd, in_wr;
    logic   g_valid, g_res_ready;
`ifdef ARB_ROUND_ROBIN_EN
    logic   last_grant;
    assign pick = (i_req_valid && d_req_valid) ? ~last_grant : d_req_valid;
`else
    assign pick = d_req_valid;
`endif
    assign in_req      = (state == REQ);
    assign in_rd       = (state == WAIT_RD);
    assign in_wr       = (state == WAIT_WR);
    assign g_valid     = grant ? d_req_valid : i_req_valid;
    assign g_res_ready = grant ? d_res_ready : i_res_ready;
    // Every output is qualified by state, so the async reset to IDLE zeroes them at once.
    assign m_req_valid = in_req & g_valid;
    assign m_req_addr  = in_req ? (grant ? d_req_addr : i_req_addr) : '0;
    assign m_write_en  = in_req & grant & d_write_en;
    assign m_req_Wdata = (in_req & grant) ? d_req_Wdata : '0;
    assign i_req_ready = in_req & ~grant & m_req_ready;
    assign d_req_ready = in_req & grant & m_req_ready;
    assign m_res_ready = in_rd & g_res_ready;
    assign i_res_valid = in_rd & ~grant & m_res_valid;
    assign d_res_valid = in_rd & grant & m_res_valid;
    assign i_res_Rdata = in_rd ? m_res_Rdata : '0;
    assign d_res_Rdata = in_rd ? m_res_Rdata : '0;
    assign d_axi_Wdone = in_wr ? m_axi_Wdone : '0;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            grant <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE:
                    if (i_req_valid || d_req_valid) begin
                        grant <= pick;
                        state <= REQ;
                    end
                REQ:
                    if (!g_valid) state <= IDLE;
                    else if (m_req_ready) begin
                        state <= m_write_en ? WAIT_WR : WAIT_RD;
`ifdef ARB_ROUND_ROBIN_EN
                        last_grant <= grant;
`endif
                    end
                WAIT_RD:
                    if (m_res_valid && m_res_ready) state <= IDLE;
                WAIT_WR:
                    // Write-then-fill lock: DCache keeps the port for its refill.
                    if (m_axi_Wdone != 2'b00) begin
                        state <= REQ;
                        grant <= 1'b1;
                    end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
